// File: rtl/alarm_bank.sv
// Alarm bank: NUM_ALARMS programmable alarm channels compared against the
// current clock time, with a single ring/snooze sequencer shared by all
// channels. Define ALARM_SNOOZE_EN to build the snooze path; without it the
// SNOOZE input is ignored and SNOOZED is tied low.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | nothing sounding, waiting for a channel's match to rise
//   RINGING     | RING_IDX channel sounding, counting seconds to auto-stop
//   SNOOZE_WAIT | RING_IDX channel snoozed, counting minutes until re-ring
module alarm_bank #(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  AMPM,
  input  logic [3:0]            HOUR,
  input  logic [2:0]            MINHIGH,
  input  logic [3:0]            MINLOW,
  input  logic                  SEC_TICK,
  input  logic                  MIN_TICK,
  input  logic                  WR_EN,
  input  logic [IW-1:0]         WR_IDX,
  input  logic                  WR_AMPM,
  input  logic [3:0]            WR_HOUR,
  input  logic [2:0]            WR_MINHIGH,
  input  logic [3:0]            WR_MINLOW,
  input  logic                  WR_ENABLE,
  input  logic                  SNOOZE,
  input  logic                  STOP,
  output logic [NUM_ALARMS-1:0] MATCH,
  output logic                  RING,
  output logic [IW-1:0]         RING_IDX,
  output logic                  SNOOZED
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE_WAIT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1} state_t;
`endif

  logic [NUM_ALARMS-1:0] al_ampm;
  logic [NUM_ALARMS-1:0] al_en;
  logic [3:0]            al_hour    [NUM_ALARMS];
  logic [2:0]            al_minhigh [NUM_ALARMS];
  logic [3:0]            al_minlow  [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] match_now, match_q, match_prev, trig;
  state_t                state_q, state_d;
  logic [7:0]            sec_cnt_q, sec_cnt_d;
  logic [IW-1:0]         ring_idx_q, ring_idx_d;

  // Lowest-index set bit wins when several channels fire together.
  function automatic logic [IW-1:0] lowest(input logic [NUM_ALARMS-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Alarm register file; indices beyond the last channel match no slot.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      al_ampm <= '0;
      al_en   <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_hour[i]    <= '0;
        al_minhigh[i] <= '0;
        al_minlow[i]  <= '0;
      end
    end else if (WR_EN) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (WR_IDX == IW'(i)) begin
          al_ampm[i]    <= WR_AMPM;
          al_hour[i]    <= WR_HOUR;
          al_minhigh[i] <= WR_MINHIGH;
          al_minlow[i]  <= WR_MINLOW;
          al_en[i]      <= WR_ENABLE;
        end
      end
    end
  end

  // Per-channel equality of the armed alarm time against the current time.
  always_comb begin
    match_now = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match_now[i] = al_en[i] && (al_ampm[i] == AMPM) && (al_hour[i] == HOUR) &&
                     (al_minhigh[i] == MINHIGH) && (al_minlow[i] == MINLOW);
    end
  end

  // Registered match plus one cycle of history for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      match_q    <= '0;
      match_prev <= '0;
    end else begin
      match_q    <= match_now;
      match_prev <= match_q;
    end
  end

  assign MATCH = match_q;
  assign trig  = match_q & ~match_prev;

`ifdef ALARM_SNOOZE_EN
  logic [3:0]            min_cnt_q, min_cnt_d;
  logic [NUM_ALARMS-1:0] ring_mask, trig_other;

  // A retrigger of the snoozed channel itself must not preempt its snooze.
  always_comb begin
    ring_mask = '0;
    for (int i = 0; i < NUM_ALARMS; i++) ring_mask[i] = (ring_idx_q == IW'(i));
  end
  assign trig_other = trig & ~ring_mask;

  // Snooze minute counter register.
  always_ff @(posedge CLK) begin
    if (!RESETN) min_cnt_q <= '0;
    else         min_cnt_q <= min_cnt_d;
  end
`else
  logic unused_snooze_inputs;
  assign unused_snooze_inputs = ^{SNOOZE, MIN_TICK};
`endif

  // Sequencer state, second counter and ringing channel registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      sec_cnt_q  <= '0;
      ring_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      ring_idx_q <= ring_idx_d;
    end
  end

  // Next-state logic; STOP always takes priority over SNOOZE.
  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    ring_idx_d = ring_idx_q;
`ifdef ALARM_SNOOZE_EN
    min_cnt_d  = min_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|trig) begin
          state_d    = RINGING;
          ring_idx_d = lowest(trig);
          sec_cnt_d  = '0;
        end
      end
      RINGING: begin
        if (STOP) begin
          state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (SNOOZE) begin
          state_d   = SNOOZE_WAIT;
          min_cnt_d = 4'(SNOOZE_MIN);
`endif
        end else if (SEC_TICK) begin
          if (sec_cnt_q == 8'(RING_TIMEOUT_S - 1)) state_d = IDLE;
          else                                     sec_cnt_d = sec_cnt_q + 8'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE_WAIT: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (|trig_other) begin
          state_d    = RINGING;
          ring_idx_d = lowest(trig_other);
          sec_cnt_d  = '0;
        end else if (MIN_TICK) begin
          min_cnt_d = min_cnt_q - 4'd1;
          if (min_cnt_q == 4'd1) begin
            state_d   = RINGING;
            sec_cnt_d = '0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign RING     = (state_q == RINGING);
  assign RING_IDX = ring_idx_q;
`ifdef ALARM_SNOOZE_EN
  assign SNOOZED  = (state_q == SNOOZE_WAIT);
`else
  assign SNOOZED  = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: the driver steps a behavioural model each
// cycle and queues the expected outputs; the monitor pops and compares them.
module tb_alarm_bank;
  localparam int N  = 3;
  localparam int TO = 60;
  localparam int SM = 5;
  localparam int IW = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESETN, AMPM, SEC_TICK, MIN_TICK, WR_EN, WR_AMPM, WR_ENABLE, SNOOZE, STOP;
  logic [3:0]    HOUR, MINLOW, WR_HOUR, WR_MINLOW;
  logic [2:0]    MINHIGH, WR_MINHIGH;
  logic [IW-1:0] WR_IDX;
  logic [N-1:0]  MATCH;
  logic          RING, SNOOZED;
  logic [IW-1:0] RING_IDX;

  alarm_bank #(.NUM_ALARMS(N), .RING_TIMEOUT_S(TO), .SNOOZE_MIN(SM)) dut (
    .CLK(CLK), .RESETN(RESETN), .AMPM(AMPM), .HOUR(HOUR), .MINHIGH(MINHIGH),
    .MINLOW(MINLOW), .SEC_TICK(SEC_TICK), .MIN_TICK(MIN_TICK), .WR_EN(WR_EN),
    .WR_IDX(WR_IDX), .WR_AMPM(WR_AMPM), .WR_HOUR(WR_HOUR), .WR_MINHIGH(WR_MINHIGH),
    .WR_MINLOW(WR_MINLOW), .WR_ENABLE(WR_ENABLE), .SNOOZE(SNOOZE), .STOP(STOP),
    .MATCH(MATCH), .RING(RING), .RING_IDX(RING_IDX), .SNOOZED(SNOOZED)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0]  match;
    logic          ring;
    logic [IW-1:0] idx;
    logic          snz;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_total = 0, cyc_n = 0;

  // Reference model: alarm times as minute keys, ring/snooze as time left.
  int       m_key [N];
  bit       m_en  [N];
  bit [N-1:0] m_match, m_prev;
  int       m_mode;   // 0 quiet, 1 ringing, 2 snoozed
  int       m_idx, m_ring_left, m_snz_left;

  function automatic int tkey(input logic a, input logic [3:0] h,
                              input logic [2:0] mh, input logic [3:0] ml);
    return ((int'(a) * 16 + int'(h)) * 8 + int'(mh)) * 16 + int'(ml);
  endfunction

  function automatic int first_set(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    bit [N-1:0] trig, other, nm;
    int now;
    if (!RESETN) begin
      for (int i = 0; i < N; i++) begin m_key[i] = 0; m_en[i] = 0; end
      m_match = '0; m_prev = '0; m_mode = 0; m_idx = 0;
      m_ring_left = 0; m_snz_left = 0;
      return;
    end
    trig = m_match & ~m_prev;
    now  = tkey(AMPM, HOUR, MINHIGH, MINLOW);
    for (int i = 0; i < N; i++) nm[i] = m_en[i] && (m_key[i] == now);
    if (m_mode == 0) begin
      if (trig != 0) begin m_mode = 1; m_idx = first_set(trig); m_ring_left = TO; end
    end else if (m_mode == 1) begin
      if (STOP) m_mode = 0;
      else if (SNZ && SNOOZE) begin m_mode = 2; m_snz_left = SM; end
      else if (SEC_TICK) begin
        m_ring_left--;
        if (m_ring_left == 0) m_mode = 0;
      end
    end else begin
      other = trig;
      other[m_idx] = 1'b0;
      if (STOP) m_mode = 0;
      else if (other != 0) begin m_mode = 1; m_idx = first_set(other); m_ring_left = TO; end
      else if (MIN_TICK) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_mode = 1; m_ring_left = TO; end
      end
    end
    if (WR_EN && int'(WR_IDX) < N) begin
      m_key[WR_IDX] = tkey(WR_AMPM, WR_HOUR, WR_MINHIGH, WR_MINLOW);
      m_en[WR_IDX]  = WR_ENABLE;
    end
    m_prev  = m_match;
    m_match = nm;
  endtask

  // One clock: model the coming edge, queue its result, clear pulses.
  task automatic cyc();
    exp_t e;
    model_edge();
    e.match = m_match;
    e.ring  = (m_mode == 1);
    e.idx   = IW'(m_idx);
    e.snz   = (m_mode == 2);
    exp_q.push_back(e);
    @(negedge CLK);
    RESETN = 1'b1; WR_EN = 1'b0; SEC_TICK = 1'b0; MIN_TICK = 1'b0;
    SNOOZE = 1'b0; STOP = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_time(input logic a, input logic [3:0] h,
                          input logic [2:0] mh, input logic [3:0] ml);
    AMPM = a; HOUR = h; MINHIGH = mh; MINLOW = ml;
  endtask

  task automatic write_ch(input int idx, input logic a, input logic [3:0] h,
                          input logic [2:0] mh, input logic [3:0] ml, input logic en);
    WR_EN = 1'b1; WR_IDX = IW'(idx); WR_AMPM = a; WR_HOUR = h;
    WR_MINHIGH = mh; WR_MINLOW = ml; WR_ENABLE = en;
    cyc();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
  endtask

  // Monitor: every edge that the driver has modelled is compared here.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("MATCH",    32'(MATCH),    32'(e.match));
        chk("RING",     32'(RING),     32'(e.ring));
        chk("RING_IDX", 32'(RING_IDX), 32'(e.idx));
        chk("SNOOZED",  32'(SNOOZED),  32'(e.snz));
      end
    end
  end

  initial begin
    RESETN = 1'b0; WR_EN = 1'b0; SEC_TICK = 1'b0; MIN_TICK = 1'b0;
    SNOOZE = 1'b0; STOP = 1'b0; WR_IDX = '0; WR_AMPM = 1'b0; WR_HOUR = '0;
    WR_MINHIGH = '0; WR_MINLOW = '0; WR_ENABLE = 1'b0;
    set_time(1'b0, 4'd0, 3'd0, 4'd0);
    @(negedge CLK);
    RESETN = 1'b0; cyc();
    RESETN = 1'b0; cyc();

    // 07:29 AM -> 07:30 AM with channel 1 armed for 07:30 AM
    set_time(1'b0, 4'd7, 3'd2, 4'd9);
    write_ch(1, 1'b0, 4'd7, 3'd3, 4'd0, 1'b1);
    idle(2);
    set_time(1'b0, 4'd7, 3'd3, 4'd0);
    idle(3);
    // auto-stop after the 60th second, no re-ring while time is held
    for (int i = 0; i < TO; i++) begin SEC_TICK = 1'b1; cyc(); cyc(); end
    for (int i = 0; i < 10; i++) begin SEC_TICK = 1'b1; cyc(); end

    // channels 0 and 2 both at 06:00 PM: lowest index wins
    write_ch(1, 1'b0, 4'd7, 3'd3, 4'd0, 1'b0);
    write_ch(0, 1'b1, 4'd6, 3'd0, 4'd0, 1'b1);
    write_ch(2, 1'b1, 4'd6, 3'd0, 4'd0, 1'b1);
    set_time(1'b1, 4'd5, 3'd5, 4'd9);
    idle(2);
    set_time(1'b1, 4'd6, 3'd0, 4'd0);
    idle(3);
    // disarming the ringing channel leaves the ring alone
    write_ch(0, 1'b1, 4'd6, 3'd0, 4'd0, 1'b0);
    idle(2);
    // snooze, minute countdown, then STOP beats SNOOZE
    SNOOZE = 1'b1; cyc();
    idle(2);
    for (int i = 0; i < SM; i++) begin MIN_TICK = 1'b1; cyc(); cyc(); end
    idle(2);
    STOP = 1'b1; SNOOZE = 1'b1; cyc();
    idle(2);
    STOP = 1'b1; SNOOZE = 1'b1; cyc();   // no effect when quiet

    // reset while ringing: everything disarmed, held match stays quiet
    write_ch(1, 1'b1, 4'd6, 3'd0, 4'd0, 1'b1);
    idle(3);
    RESETN = 1'b0; cyc();
    idle(5);

    // write to a channel number that does not exist
    write_ch(3, 1'b1, 4'd6, 3'd0, 4'd0, 1'b1);
    idle(4);

    // randomized traffic on a small set of times so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      RESETN = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0)
        set_time(1'($urandom_range(0, 1)), 4'(6 + $urandom_range(0, 1)),
                 3'($urandom_range(0, 1) * 3), 4'($urandom_range(0, 1) * 9));
      SEC_TICK = ($urandom_range(0, 2) == 0);
      MIN_TICK = ($urandom_range(0, 4) == 0);
      SNOOZE   = ($urandom_range(0, 39) == 0);
      STOP     = ($urandom_range(0, 59) == 0);
      WR_EN    = ($urandom_range(0, 9) == 0);
      WR_IDX     = IW'($urandom_range(0, 3));
      WR_AMPM    = 1'($urandom_range(0, 1));
      WR_HOUR    = 4'(6 + $urandom_range(0, 1));
      WR_MINHIGH = 3'($urandom_range(0, 1) * 3);
      WR_MINLOW  = 4'($urandom_range(0, 1) * 9);
      WR_ENABLE  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    @(posedge CLK);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4, number of independently programmable alarm channels (1..16).
REQ-002 SHALL have parameter RING_TIMEOUT_S, default 60, seconds an unattended alarm rings before auto-stop (1..255).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..15).
REQ-004 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port RESETN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports AMPM/HOUR/MINHIGH/MINLOW  input  1/4/3/4  current clock time.
REQ-007 SHALL have ports SEC_TICK, MIN_TICK  input  1 each  one-cycle pulses per second/minute from the timebase.
REQ-008 SHALL have port WR_EN  input  1  write strobe for alarm programming.
REQ-009 SHALL have port WR_IDX  input  IW=max(1,clog2(NUM_ALARMS))  channel written.
REQ-010 SHALL have ports WR_AMPM/WR_HOUR/WR_MINHIGH/WR_MINLOW/WR_ENABLE  input  1/4/3/4/1  alarm time and arm bit.
REQ-011 SHALL have ports SNOOZE, STOP  input  1 each  one-cycle user pulses.
REQ-012 SHALL have port MATCH  output  NUM_ALARMS  registered per-channel equality (armed AND all four time fields equal).
REQ-013 SHALL have ports RING  output  1  alarm sounding; RING_IDX  output  IW  channel ringing/snoozed; SNOOZED  output  1  snooze active.

Function
REQ-014 SHALL store per channel AMPM, HOUR, MINHIGH, MINLOW, ENABLE; WR_EN loads channel WR_IDX next edge; WR_IDX >= NUM_ALARMS ignored.
REQ-015 SHALL compute MATCH[i] each cycle from current inputs and stored values, registered (1-cycle latency); a write takes effect on the following cycle's compare.
REQ-016 SHALL detect trigger as rising edge of MATCH[i] (MATCH[i]=1, previous MATCH[i]=0); a held match triggers once.
REQ-017 SHALL select the lowest-index channel when multiple triggers occur in one cycle.
REQ-018 SHALL implement FSM IDLE, RINGING, SNOOZE_WAIT; RING=1 only in RINGING, SNOOZED=1 only in SNOOZE_WAIT.
REQ-019 IDLE: trigger -> RINGING next edge, RING_IDX=selected channel, second counter cleared.
REQ-020 RINGING: STOP -> IDLE; SNOOZE -> SNOOZE_WAIT, minute counter loaded SNOOZE_MIN; SEC_TICK increments counter, reaching RING_TIMEOUT_S -> IDLE; new triggers ignored.
REQ-021 SNOOZE_WAIT: MIN_TICK decrements counter; decrement to 0 -> RINGING same RING_IDX, second counter cleared; STOP -> IDLE; new trigger on another channel -> RINGING with that channel (preempts snooze).
REQ-022 STOP and SNOOZE same cycle: STOP wins. STOP/SNOOZE in IDLE: no effect.
REQ-023 Rewriting or disarming the active channel SHALL NOT change FSM state or RING_IDX.
REQ-024 RING_IDX SHALL hold last value in IDLE.

Reset
REQ-025 RESETN=0 at edge SHALL clear all alarm registers and ENABLE bits, MATCH and edge history to 0, FSM to IDLE, counters to 0, RING=0, RING_IDX=0, SNOOZED=0.
REQ-026 Reset mid-RINGING or mid-SNOOZE_WAIT SHALL abort to IDLE with no pending ring; a time already matching after reset does not trigger (channels disarmed).

Configuration
REQ-027 Macro ALARM_SNOOZE_EN: defined -> snooze per REQ-020/021; undefined -> SNOOZE input ignored, SNOOZE_WAIT and minute counter not built, SNOOZED tied 0.

Verification
REQ-028 Write ch1=07:30 AM armed; drive time 07:29 AM -> 07:30 AM -> MATCH[1]=1 one cycle later, RING=1 and RING_IDX=1 the next cycle.
REQ-029 Ringing, hold time 07:30 for 60 SEC_TICKs -> RING falls after 60th tick; no re-ring while time stays 07:30.
REQ-030 Ch0 and ch2 both 06:00 PM armed, time reaches 06:00 PM -> RING_IDX=0.
REQ-031 (ALARM_SNOOZE_EN) ringing, SNOOZE pulse -> SNOOZED=1, RING=0; 5 MIN_TICKs -> RING=1, RING_IDX unchanged; STOP+SNOOZE same cycle -> IDLE.
REQ-032 Ringing, RESETN=0 one cycle -> RING=0, MATCH=0, all channels disarmed; same time held -> no ring.
